// File: rtl/mcb_port_model.sv
// Stand-in for one Spartan-6 MCB user port: command/write/read FIFOs in front of
// a small word-addressed memory, with bursts sequenced by a command FSM.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a command; pops it (no-ops are popped and ignored)
// S_WAIT  | command latency countdown before the first beat
// S_WRITE | one beat per cycle from the write FIFO into memory
// S_READ  | one beat per cycle from memory into the read FIFO
module mcb_port_model #(
  parameter int MEM_DEPTH       = 256,
  parameter int CMD_FIFO_DEPTH  = 4,
  parameter int DATA_FIFO_DEPTH = 64,
  parameter int CMD_LATENCY     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_en,
  input  logic [2:0]  cmd_instr,
  input  logic [5:0]  cmd_bl,
  input  logic [29:0] cmd_addr,
  output logic        cmd_full,
  output logic        cmd_empty,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        wr_full,
  output logic        wr_empty,
  output logic [6:0]  wr_count,
  output logic        wr_underrun,
  output logic        wr_error,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_empty,
  output logic        rd_full,
  output logic [6:0]  rd_count,
  output logic        rd_overflow,
  output logic        rd_error
);
  localparam int AW  = $clog2(MEM_DEPTH);
  localparam int CAW = $clog2(CMD_FIFO_DEPTH);
  localparam int DAW = $clog2(DATA_FIFO_DEPTH);
  localparam int LW  = $clog2(CMD_LATENCY + 1);
  localparam int CW  = 3 + 6 + AW;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_READ} state_t;

  state_t         state;
  logic           op_write;
  logic [5:0]     beats_left;
  logic [AW-1:0]  index;
  logic [LW-1:0]  wait_cnt;

  logic [31:0]    mem [MEM_DEPTH];

  // Only the word index of the address is kept; the remaining bits are don't-care.
  logic           addr_unused;
  assign addr_unused = ^{cmd_addr[29:2+AW], cmd_addr[1:0]};

  logic [CW-1:0]  cmd_mem [CMD_FIFO_DEPTH];
  logic [CAW-1:0] cmd_wptr, cmd_rptr;
  logic [CAW:0]   cmd_cnt;
  logic           cmd_push, cmd_pop;
  logic [CW-1:0]  cmd_head;
  logic [2:0]     head_instr;
  logic [5:0]     head_bl;
  logic [AW-1:0]  head_index;

  logic [31:0]    wr_mem [DATA_FIFO_DEPTH];
  logic [DAW-1:0] wr_wptr, wr_rptr;
  logic [DAW:0]   wr_cnt;
  logic           wr_push, wr_pop;

  logic [31:0]    rd_mem [DATA_FIFO_DEPTH];
  logic [DAW-1:0] rd_wptr, rd_rptr;
  logic [DAW:0]   rd_cnt;
  logic           rd_push, rd_pop;

  assign cmd_full  = (cmd_cnt == (CAW+1)'(CMD_FIFO_DEPTH));
  assign cmd_empty = (cmd_cnt == '0);
  assign wr_full   = (wr_cnt == (DAW+1)'(DATA_FIFO_DEPTH));
  assign wr_empty  = (wr_cnt == '0);
  assign rd_full   = (rd_cnt == (DAW+1)'(DATA_FIFO_DEPTH));
  assign rd_empty  = (rd_cnt == '0);
  assign wr_count  = 7'(wr_cnt);
  assign rd_count  = 7'(rd_cnt);
  assign rd_data   = rd_empty ? 32'd0 : rd_mem[rd_rptr];

  assign cmd_head   = cmd_mem[cmd_rptr];
  assign head_instr = cmd_head[CW-1 -: 3];
  assign head_bl    = cmd_head[AW +: 6];
  assign head_index = cmd_head[AW-1:0];

  assign cmd_push = cmd_en && !cmd_full;
  assign cmd_pop  = (state == S_IDLE) && !cmd_empty;
  assign wr_push  = wr_en && !wr_full;
  assign wr_pop   = (state == S_WRITE) && !wr_empty;
  assign rd_pop   = rd_en && !rd_empty;
  // A full read FIFO still accepts a beat when its head leaves on the same edge.
  assign rd_push  = (state == S_READ) && (!rd_full || rd_pop);

  // Storage arrays carry no reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wptr] <= {cmd_instr, cmd_bl, cmd_addr[2 +: AW]};
    if (wr_push)  wr_mem[wr_wptr]   <= wr_data;
    if (rd_push)  rd_mem[rd_wptr]   <= mem[index];
    if (state == S_WRITE) mem[index] <= wr_empty ? 32'd0 : wr_mem[wr_rptr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_wptr <= '0;
      cmd_rptr <= '0;
      cmd_cnt  <= '0;
      wr_wptr  <= '0;
      wr_rptr  <= '0;
      wr_cnt   <= '0;
      rd_wptr  <= '0;
      rd_rptr  <= '0;
      rd_cnt   <= '0;
    end else begin
      if (cmd_push) cmd_wptr <= cmd_wptr + 1'b1;
      if (cmd_pop)  cmd_rptr <= cmd_rptr + 1'b1;
      if (cmd_push && !cmd_pop)      cmd_cnt <= cmd_cnt + 1'b1;
      else if (!cmd_push && cmd_pop) cmd_cnt <= cmd_cnt - 1'b1;

      if (wr_push) wr_wptr <= wr_wptr + 1'b1;
      if (wr_pop)  wr_rptr <= wr_rptr + 1'b1;
      if (wr_push && !wr_pop)      wr_cnt <= wr_cnt + 1'b1;
      else if (!wr_push && wr_pop) wr_cnt <= wr_cnt - 1'b1;

      if (rd_push) rd_wptr <= rd_wptr + 1'b1;
      if (rd_pop)  rd_rptr <= rd_rptr + 1'b1;
      if (rd_push && !rd_pop)      rd_cnt <= rd_cnt + 1'b1;
      else if (!rd_push && rd_pop) rd_cnt <= rd_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      op_write    <= 1'b0;
      beats_left  <= '0;
      index       <= '0;
      wait_cnt    <= '0;
      wr_underrun <= 1'b0;
      wr_error    <= 1'b0;
      rd_overflow <= 1'b0;
      rd_error    <= 1'b0;
    end else begin
      wr_underrun <= 1'b0;
      rd_overflow <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!cmd_empty && !head_instr[2]) begin
            op_write   <= !head_instr[0];
            beats_left <= head_bl;
            index      <= head_index;
            wait_cnt   <= LW'(CMD_LATENCY);
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == LW'(1)) state <= op_write ? S_WRITE : S_READ;
        end
        S_WRITE: begin
          if (wr_empty) begin
            wr_underrun <= 1'b1;
            wr_error    <= 1'b1;
          end
          index      <= index + 1'b1;
          beats_left <= beats_left - 1'b1;
          if (beats_left == '0) state <= S_IDLE;
        end
        S_READ: begin
          if (!rd_push) begin
            rd_overflow <= 1'b1;
            rd_error    <= 1'b1;
          end
          index      <= index + 1'b1;
          beats_left <= beats_left - 1'b1;
          if (beats_left == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mcb_port_model.sv
// Directed bench for mcb_port_model: single-word vector table plus burst,
// wrap, underrun, overflow and command flow-control sequences.
module tb_mcb_port_model;
  logic        clk, reset;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_addr;
  logic        cmd_full, cmd_empty;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_full, wr_empty;
  logic [6:0]  wr_count;
  logic        wr_underrun, wr_error;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_empty, rd_full;
  logic [6:0]  rd_count;
  logic        rd_overflow, rd_error;

  int n_cmp = 0;
  int n_err = 0;

  mcb_port_model dut (
    .clk(clk), .reset(reset),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_addr(cmd_addr),
    .cmd_full(cmd_full), .cmd_empty(cmd_empty),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .wr_empty(wr_empty),
    .wr_count(wr_count), .wr_underrun(wr_underrun), .wr_error(wr_error),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .rd_full(rd_full),
    .rd_count(rd_count), .rd_overflow(rd_overflow), .rd_error(rd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] wd;
    logic [29:0] ra;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [31:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
    cmd_en = 1'b1;
    cmd_instr = instr;
    cmd_bl = bl;
    cmd_addr = addr;
    tick();
    cmd_en = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_rd(input string name, input int budget);
    int n;
    n = 0;
    while (rd_empty && n < budget) begin
      tick();
      n++;
    end
    check({name, "_rd_ready"}, {31'd0, rd_empty}, 32'd0);
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    check(name, rd_data, exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    int cnt;

    vecs[0] = '{wa: 30'h200,      wd: 32'h12345678, ra: 30'h200,      exp: 32'h12345678};
    vecs[1] = '{wa: 30'h204,      wd: 32'hCAFEF00D, ra: 30'h20000200, exp: 32'h12345678};
    vecs[2] = '{wa: 30'h3FFFFFFF, wd: 32'hDEADBEEF, ra: 30'h3FC,      exp: 32'hDEADBEEF};
    vecs[3] = '{wa: 30'h207,      wd: 32'h0BADF00D, ra: 30'h204,      exp: 32'h0BADF00D};
    vecs[4] = '{wa: 30'h10,       wd: 32'h55AA55AA, ra: 30'h410,      exp: 32'h55AA55AA};

    reset = 1'b0;
    cmd_en = 1'b0; cmd_instr = '0; cmd_bl = '0; cmd_addr = '0;
    wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    wait_cycles(3);
    reset = 1'b1;
    tick();

    check("rst_cmd_empty", {31'd0, cmd_empty}, 32'd1);
    check("rst_wr_empty",  {31'd0, wr_empty},  32'd1);
    check("rst_rd_empty",  {31'd0, rd_empty},  32'd1);
    check("rst_cmd_full",  {31'd0, cmd_full},  32'd0);
    check("rst_wr_full",   {31'd0, wr_full},   32'd0);
    check("rst_rd_full",   {31'd0, rd_full},   32'd0);
    check("rst_wr_count",  {25'd0, wr_count},  32'd0);
    check("rst_rd_count",  {25'd0, rd_count},  32'd0);
    check("rst_flags", {28'd0, wr_underrun, wr_error, rd_overflow, rd_error}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);

    // Single-word write/read vectors, including ignored address bits.
    for (int i = 0; i < 5; i++) begin
      push_wr(vecs[i].wd);
      push_cmd(3'b000, 6'd0, vecs[i].wa);
      push_cmd(3'b011, 6'd0, vecs[i].ra);
      wait_rd($sformatf("vec%0d", i), 40);
      pop_check($sformatf("vec%0d_data", i), vecs[i].exp);
      check($sformatf("vec%0d_empty", i), {31'd0, rd_empty}, 32'd1);
    end

    // No-op command is consumed without any transfer.
    push_cmd(3'b111, 6'd5, 30'h40);
    wait_cycles(10);
    check("noop_cmd_empty", {31'd0, cmd_empty}, 32'd1);
    check("noop_rd_empty",  {31'd0, rd_empty},  32'd1);

    // Write burst then read-back with exact latency.
    for (int i = 0; i < 4; i++) push_wr(32'hA0 + i);
    check("burst_wr_count", {25'd0, wr_count}, 32'd4);
    push_cmd(3'b000, 6'd3, 30'h40);
    wait_cycles(12);
    check("burst_wr_count_0", {25'd0, wr_count}, 32'd0);
    push_cmd(3'b001, 6'd3, 30'h40);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("lat_rd_empty_e%0d", k), {31'd0, rd_empty}, (k < 6) ? 32'd1 : 32'd0);
    end
    wait_cycles(4);
    for (int i = 0; i < 4; i++) pop_check($sformatf("burst_rd%0d", i), 32'hA0 + i);

    // Index wrap-around at the top of memory.
    push_wr(32'h11);
    push_wr(32'h22);
    push_cmd(3'b010, 6'd1, 30'h3FC);
    wait_cycles(12);
    push_cmd(3'b001, 6'd0, 30'h0);
    wait_rd("wrap0", 40);
    pop_check("wrap_addr0", 32'h22);
    push_cmd(3'b001, 6'd0, 30'h3FC);
    wait_rd("wrap1", 40);
    pop_check("wrap_last", 32'h11);

    // Underrun: 4 beats, 2 words available.
    push_wr(32'h33);
    push_wr(32'h44);
    push_cmd(3'b000, 6'd3, 30'h80);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_underrun) cnt++;
    end
    check("underrun_pulses", cnt, 32'd2);
    check("underrun_error", {31'd0, wr_error}, 32'd1);
    push_cmd(3'b001, 6'd3, 30'h80);
    wait_rd("underrun_rd", 40);
    wait_cycles(4);
    pop_check("underrun_rd0", 32'h33);
    pop_check("underrun_rd1", 32'h44);
    pop_check("underrun_rd2", 32'h0);
    pop_check("underrun_rd3", 32'h0);
    check("underrun_rd_error", {31'd0, rd_error}, 32'd0);

    // Fill write FIFO to the brim; the extra word must be dropped.
    for (int i = 0; i < 64; i++) push_wr(32'h1000 + i);
    check("wr_full_set", {31'd0, wr_full}, 32'd1);
    push_wr(32'hFFFF);
    check("wr_full_count", {25'd0, wr_count}, 32'd64);
    push_cmd(3'b000, 6'd63, 30'h100);
    wait_cycles(75);
    check("wr_drain_count", {25'd0, wr_count}, 32'd0);

    // Overflow: two 64-beat reads with nobody popping.
    push_cmd(3'b001, 6'd63, 30'h100);
    push_cmd(3'b011, 6'd63, 30'h0);
    cnt = 0;
    for (int i = 0; i < 160; i++) begin
      tick();
      if (rd_overflow) cnt++;
    end
    check("ovf_pulses", cnt, 32'd64);
    check("ovf_rd_count", {25'd0, rd_count}, 32'd64);
    check("ovf_rd_full", {31'd0, rd_full}, 32'd1);
    check("ovf_rd_error", {31'd0, rd_error}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (rd_data !== 32'h1000 + i) cnt++;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    if (cnt != 0) begin
      n_err++;
      $display("FAIL ovf_drain: %0d words wrong, expected 0", cnt);
    end
    check("ovf_drained_empty", {31'd0, rd_empty}, 32'd1);

    // Command flow control behind a long write burst.
    push_cmd(3'b000, 6'd63, 30'h200);
    tick();
    check("flow_cmd_popped", {31'd0, cmd_empty}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      cmd_en = 1'b1;
      cmd_instr = 3'b001;
      cmd_bl = 6'd0;
      cmd_addr = 30'h100 + 30'(4 * k);
      tick();
      check($sformatf("flow_cmd_full%0d", k), {31'd0, cmd_full}, (k >= 3) ? 32'd1 : 32'd0);
    end
    cmd_en = 1'b0;
    wait_cycles(130);
    check("flow_rd_count", {25'd0, rd_count}, 32'd4);
    for (int i = 0; i < 4; i++) pop_check($sformatf("flow_rd%0d", i), 32'h1000 + i);
    check("flow_rd_empty", {31'd0, rd_empty}, 32'd1);
    check("flow_cmd_empty", {31'd0, cmd_empty}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mcb_port_model.md
Name: mcb_port_model

Overview:
- Synthesizable single-port stand-in for the Spartan-6 MCB user port.
- Sits directly downstream of traffic_generator. It consumes that block's command and write-data streams and returns read data, so the UART→memory path can be checked in simulation and on boards without DDR.
- Internals: command FIFO, write-data FIFO, read-data FIFO, small word-addressed memory, and a command-execution FSM.

Parameters:
- MEM_DEPTH, 256, memory size in 32-bit words (power of 2).
- CMD_FIFO_DEPTH, 4, command FIFO entries (power of 2).
- DATA_FIFO_DEPTH, 64, write and read data FIFO entries each (power of 2, ≤64).
- CMD_LATENCY, 4, idle cycles between command pop and first data transfer (≥1).

Ports:
- clk  in  1  single clock for all paths.
- reset  in  1  asynchronous, active-low (0 = reset).
- cmd_en  in  1  push command when high.
- cmd_instr  in  3  000 write, 001 read, 010 write+AP, 011 read+AP; others = no-op.
- cmd_bl  in  6  burst length minus 1.
- cmd_addr  in  30  byte address.
- cmd_full  out  1  command FIFO full.
- cmd_empty  out  1  command FIFO empty.
- wr_en  in  1  push wr_data.
- wr_data  in  32  write word.
- wr_full  out  1  write FIFO full.
- wr_empty  out  1  write FIFO empty.
- wr_count  out  7  write FIFO occupancy.
- wr_underrun  out  1  one-cycle pulse when a write needs data and the FIFO is empty.
- wr_error  out  1  sticky underrun flag.
- rd_en  in  1  pop read FIFO head.
- rd_data  out  32  read FIFO head (first-word fall-through).
- rd_empty  out  1  read FIFO empty.
- rd_full  out  1  read FIFO full.
- rd_count  out  7  read FIFO occupancy.
- rd_overflow  out  1  one-cycle pulse when a read word is dropped.
- rd_error  out  1  sticky overflow flag.

Behaviour:
- Reset values:
  - All FIFOs flushed.
  - cmd_empty=1, wr_empty=1, rd_empty=1.
  - cmd_full=0, wr_full=0, rd_full=0.
  - wr_count=0, rd_count=0.
  - wr_underrun=0, wr_error=0, rd_overflow=0, rd_error=0.
  - rd_data=0.
  - FSM in IDLE.
  - Memory contents are not reset.
- Reset is honoured mid-burst: the burst is aborted, and words already written stay in memory.
- Command FIFO:
  - cmd_en with cmd_full=0 pushes {instr, bl, addr} on the edge.
  - cmd_en while full: command silently dropped.
- Write FIFO:
  - wr_en with wr_full=0 pushes the word.
  - wr_en while full: word dropped, no flag.
- Read FIFO pop:
  - rd_en with rd_empty=0 pops the head.
  - rd_en while empty: ignored.
- Simultaneous push and pop on any FIFO: occupancy unchanged, both take effect.
- Flags and counts are registered and reflect state after each edge.
- Addressing:
  - Word index = cmd_addr[2 +: log2(MEM_DEPTH)].
  - Index increments per beat and wraps modulo MEM_DEPTH.
  - Upper address bits are ignored.
- FSM states: IDLE, WAIT, WRITE, READ.
- IDLE:
  - If the command FIFO is non-empty: pop the command, latch instr/bl/index, load wait counter = CMD_LATENCY, go to WAIT.
  - If the instr is a no-op: pop and stay in IDLE.
- WAIT: decrement the counter each cycle. At 0, go to WRITE for instr 000/010, or READ for 001/011.
- Beats per burst = bl+1 (1..64), one beat per cycle.
- WRITE, each beat:
  - If the write FIFO is non-empty: pop and store to mem[index].
  - If empty: store 0, pulse wr_underrun, set wr_error.
  - After the last beat, go to IDLE.
- READ, each beat:
  - If the read FIFO is not full, or is being popped the same cycle: push mem[index].
  - Otherwise: drop the word, pulse rd_overflow, set rd_error.
  - After the last beat, go to IDLE.
- Latency: with cmd_en sampled at edge 0 and the FSM in IDLE, the pop happens at edge 1 and the first beat at edge 2+CMD_LATENCY.
  - Read: rd_empty falls after edge 2+CMD_LATENCY.
- Back-to-back commands: IDLE pops the next command on the cycle after the last beat.
- wr_error and rd_error clear only on reset.

Test Plan:
- Reset → cmd_empty=1, wr_empty=1, rd_empty=1, all counts 0, error flags 0, rd_data=0.
- Write burst then read-back:
  - Push 0xA0..0xA3, then cmd write bl=3 addr=0x40.
  - Then cmd read bl=3 addr=0x40.
  - Expect rd_data popped in order 0xA0, 0xA1, 0xA2, 0xA3.
  - Expect rd_empty low exactly 6 cycles after the read cmd_en edge.
  - Expect wr_count returns to 0.
- Wrap-around:
  - Write bl=1 at addr=(MEM_DEPTH-1)*4 with 0x11, 0x22.
  - Read bl=0 addr=0 → 0x22.
  - Read bl=0 at the last address → 0x11.
- Underrun:
  - cmd write bl=3 with only 2 words queued → wr_underrun pulses twice, wr_error=1.
  - Read-back gives the 2 words, then 0, 0.
- Overflow:
  - With rd_en=0, issue read bl=63 twice → rd_count saturates at 64, rd_full=1, rd_overflow pulses 64 times, rd_error=1.
  - Drain yields the first burst only.
- Command flow control:
  - Push 5 commands in 5 consecutive cycles while a long write burst runs → cmd_full=1 after the 4th push; the 5th is dropped.
  - Exactly 4 commands execute in order.
